// File: rtl/uart_alu_frame_parser.sv
// uart_alu_frame_parser
//   Parses byte frames from a UART RX stage into 32-bit operand words for an ALU.
//   Frame layout: opcode, reserved, length LSB, length MSB, then (length-4)/4
//   little-endian 32-bit operands. Illegal frames raise a one-cycle frame_err_o
//   and their payload is swallowed without producing operands.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   rx_data_i/valid_i/ready_o byte stream in (valid/ready handshake)
//   opcode_o, operand_o,
//   operand_valid_o/ready_i,
//   operand_last_o           operand word out (valid/ready handshake)
//   frame_err_o              one-cycle pulse per rejected frame
module uart_alu_frame_parser #(
  parameter int unsigned MaxLenP = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  opcode_o,
  output logic [31:0] operand_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        operand_last_o,
  output logic        frame_err_o
);

  localparam int unsigned CntW    = 16;
  localparam int unsigned OpW     = 32;
  localparam logic [CntW:0] MaxLen = (CntW+1)'(MaxLenP);
  localparam logic [CntW-1:0] HdrLen = CntW'(4);
  localparam logic [CntW-1:0] MinLen = CntW'(8);

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_EMIT,
    ST_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [OpW-1:0]  operand_q, operand_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic            rdy_q;

  logic            rx_fire;
  logic [CntW-1:0] len;
  logic [CntW-1:0] cnt_dec;
  logic            opc_ok;
  logic            len_ok;
  logic            frame_ok;

  // Byte handshake uses only the registered ready, never rx_valid_i combinationally.
  assign rx_fire  = rx_valid_i && rdy_q;
  assign len      = {rx_data_i, len_lo_q};
  assign cnt_dec  = cnt_q - CntW'(1);
  assign opc_ok   = (opcode_q == 8'h10) || (opcode_q == 8'h11) || (opcode_q == 8'h12);
  assign len_ok   = (len >= MinLen) && ({1'b0, len} <= MaxLen) && (len[1:0] == 2'b00);
  assign frame_ok = opc_ok && len_ok;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_OPCODE;
      cnt_q      <= '0;
      len_lo_q   <= '0;
      opcode_q   <= '0;
      operand_q  <= '0;
      byte_idx_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_lo_q   <= len_lo_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      byte_idx_q <= byte_idx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      err_q      <= err_d;
      rdy_q      <= (state_d != ST_EMIT);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_lo_d   = len_lo_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    byte_idx_d = byte_idx_q;
    valid_d    = valid_q;
    last_d     = last_q;
    err_d      = 1'b0;

    unique case (state_q)
      ST_OPCODE: begin
        if (rx_fire) begin
          opcode_d = rx_data_i;
          state_d  = ST_RSVD;
        end
      end

      ST_RSVD: begin
        if (rx_fire) begin
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (rx_fire) begin
          len_lo_d = rx_data_i;
          state_d  = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        if (rx_fire) begin
          byte_idx_d = '0;
          if (frame_ok) begin
            cnt_d   = len - HdrLen;
            state_d = ST_PAYLOAD;
          end else begin
            err_d = 1'b1;
            // Lengths at or below the header size carry no payload to skip.
            if (len > HdrLen) begin
              cnt_d   = len - HdrLen;
              state_d = ST_DROP;
            end else begin
              cnt_d   = '0;
              state_d = ST_OPCODE;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (rx_fire) begin
          operand_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
          cnt_d      = cnt_dec;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            valid_d = 1'b1;
            last_d  = (cnt_dec == '0);
            state_d = ST_EMIT;
          end
        end
      end

      ST_EMIT: begin
        if (operand_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = (cnt_q != '0) ? ST_PAYLOAD : ST_OPCODE;
        end
      end

      ST_DROP: begin
        if (rx_fire) begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) begin
            state_d = ST_OPCODE;
          end
        end
      end

      default: begin
        state_d = ST_OPCODE;
      end
    endcase
  end

  assign rx_ready_o      = rdy_q;
  assign opcode_o        = opcode_q;
  assign operand_o       = operand_q;
  assign operand_valid_o = valid_q;
  assign operand_last_o  = last_q;
  assign frame_err_o     = err_q;

endmodule

// File: tb/tb_uart_alu_frame_parser.sv
// Self-checking bench for uart_alu_frame_parser: random byte gaps and operand
// backpressure, checked against a frame-level reference model.
module tb_uart_alu_frame_parser;

  localparam int unsigned MaxLen = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  opc;
    logic [31:0] word;
    logic        last;
    int          cyc;
  } op_t;

  logic        clk_i;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  opcode_o;
  logic [31:0] operand_o;
  logic        operand_valid_o;
  logic        operand_ready_i;
  logic        operand_last_o;
  logic        frame_err_o;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  rdy_mode = 1;   // 0 low, 1 high, 2 random
  int  exp_err = 0;
  int  err_seen = 0;
  op_t exp_q[$];
  op_t obs_q[$];

  uart_alu_frame_parser #(.MaxLenP(MaxLen)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rx_data_i      (rx_data_i),
    .rx_valid_i     (rx_valid_i),
    .rx_ready_o     (rx_ready_o),
    .opcode_o       (opcode_o),
    .operand_o      (operand_o),
    .operand_valid_o(operand_valid_o),
    .operand_ready_i(operand_ready_i),
    .operand_last_o (operand_last_o),
    .frame_err_o    (frame_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Downstream ready, changed shortly after each rising edge
  initial begin
    operand_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      case (rdy_mode)
        0:       operand_ready_i = 1'b0;
        1:       operand_ready_i = 1'b1;
        default: operand_ready_i = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Output monitor: collects accepted words, counts error pulses, checks hold rules
  initial begin
    bit  stall = 0;
    op_t held;
    held = '{8'h0, 32'h0, 1'b0, 0};
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1) begin
        if (stall) begin
          checks++;
          if (operand_valid_o !== 1'b1 || operand_o !== held.word ||
              opcode_o !== held.opc || operand_last_o !== held.last) begin
            errors++;
            $display("FAIL emit_hold: got v=%b op=%h opc=%h last=%b, want v=1 op=%h opc=%h last=%b",
                     operand_valid_o, operand_o, opcode_o, operand_last_o,
                     held.word, held.opc, held.last);
          end
        end
        if (operand_valid_o === 1'b1) begin
          checks++;
          if (rx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_emit: got rx_ready=%b, want 0", rx_ready_o);
          end
        end
        if (operand_valid_o === 1'b1 && operand_ready_i === 1'b1)
          obs_q.push_back('{opcode_o, operand_o, operand_last_o, cyc});
        if (frame_err_o === 1'b1) err_seen++;
        stall = (operand_valid_o === 1'b1) && (operand_ready_i !== 1'b1);
        held  = '{opcode_o, operand_o, operand_last_o, cyc};
      end else begin
        stall = 0;
      end
    end
  end

  // Reference model: expected words and errors from the frame rules alone
  task automatic model_frame(input bq_t f);
    int len;
    int nw;
    bit legal;
    len   = int'({f[3], f[2]});
    legal = (f[0] == 8'h10 || f[0] == 8'h11 || f[0] == 8'h12) &&
            len >= 8 && len <= int'(MaxLen) && (len % 4) == 0;
    if (!legal) begin
      exp_err++;
      return;
    end
    nw = (len - 4) / 4;
    for (int w = 0; w < nw; w++)
      exp_q.push_back('{f[0], {f[4*w+7], f[4*w+6], f[4*w+5], f[4*w+4]}, (w == nw - 1), 0});
  endtask

  task automatic make_frame(input logic [7:0] opc, input logic [15:0] len, output bq_t f);
    f = {};
    f.push_back(opc);
    f.push_back(8'($urandom));
    f.push_back(len[7:0]);
    f.push_back(len[15:8]);
    if (len > 16'd4)
      for (int i = 0; i < int'(len) - 4; i++) f.push_back(8'($urandom));
  endtask

  // Called and returns at a falling edge; the byte transfers on a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int guard;
    repeat ($urandom_range(gap_max, 0)) @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    guard = 0;
    while (rx_ready_o !== 1'b1 && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got rx_ready=%b for 200 cycles, want 1", rx_ready_o);
    end
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int gap_max);
    model_frame(f);
    foreach (f[i]) send_byte(f[i], gap_max);
  endtask

  task automatic clear_sb();
    @(negedge clk_i);
    exp_q.delete();
    obs_q.delete();
    exp_err  = 0;
    err_seen = 0;
  endtask

  task automatic wait_idle(output bit ok);
    rdy_mode = 1;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      if (obs_q.size() >= exp_q.size() && operand_valid_o === 1'b0) begin
        ok = 1;
        break;
      end
    end
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni     = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h11;
    repeat (3) @(negedge clk_i);
    checks += 6;
    if (operand_o !== 32'h0)      begin errors++; $display("FAIL rst_operand: got %h, want 0", operand_o); end
    if (opcode_o !== 8'h0)        begin errors++; $display("FAIL rst_opcode: got %h, want 0", opcode_o); end
    if (operand_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, want 0", operand_valid_o); end
    if (operand_last_o !== 1'b0)  begin errors++; $display("FAIL rst_last: got %b, want 0", operand_last_o); end
    if (frame_err_o !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b, want 0", frame_err_o); end
    if (rx_ready_o !== 1'b1)      begin errors++; $display("FAIL rst_ready: got %b, want 1", rx_ready_o); end
    rst_ni = 1'b1;
    #1;
    checks++;
    if (opcode_o !== 8'h0) begin errors++; $display("FAIL rst_release_no_accept: got opcode %h, want 0", opcode_o); end
    @(negedge clk_i);
    checks++;
    if (opcode_o !== 8'h11) begin errors++; $display("FAIL rst_first_accept: got opcode %h, want 11", opcode_o); end
    rx_valid_i = 1'b0;
    rst_ni     = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_add_frame();
    logic [7:0] raw [12] = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                             8'h02, 8'h00, 8'h00, 8'h00};
    bq_t f;
    bit  ok;
    clear_sb();
    rdy_mode = 1;
    foreach (raw[i]) f.push_back(raw[i]);
    send_frame(f, 0);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_drain: got timeout, want idle"); end
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL add_count: got %0d words, want 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i].opc !== exp_q[i].opc || obs_q[i].word !== exp_q[i].word || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL add_word%0d: got opc=%h op=%h last=%b, want opc=%h op=%h last=%b", i,
                 obs_q[i].opc, obs_q[i].word, obs_q[i].last, exp_q[i].opc, exp_q[i].word, exp_q[i].last);
      end
    end
    if (obs_q.size() == 2) begin
      checks += 2;
      if (obs_q[0].word !== 32'h1 || obs_q[1].word !== 32'h2 || obs_q[1].last !== 1'b1) begin
        errors++;
        $display("FAIL add_values: got %h/%h last=%b, want 00000001/00000002 last=1",
                 obs_q[0].word, obs_q[1].word, obs_q[1].last);
      end
      if (obs_q[1].cyc - obs_q[0].cyc != 5) begin
        errors++;
        $display("FAIL add_throughput: got %0d cycles between words, want 5", obs_q[1].cyc - obs_q[0].cyc);
      end
    end
    checks++;
    if (err_seen != 0) begin errors++; $display("FAIL add_err: got %0d pulses, want 0", err_seen); end
  endtask

  task automatic test_backpressure();
    logic [7:0] raw [12] = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                             8'h02, 8'h00, 8'h00, 8'h00};
    bq_t f;
    bit  ok;
    bit  seen;
    clear_sb();
    rdy_mode = 0;
    @(negedge clk_i);
    foreach (raw[i]) f.push_back(raw[i]);
    fork
      send_frame(f, 0);
      begin
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk_i);
          seen = (operand_valid_o === 1'b1);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_first_word: got no valid, want valid"); end
        for (int i = 0; i < 10; i++) begin
          checks += 2;
          if (operand_o !== 32'h1 || operand_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d: got op=%h v=%b, want 00000001 v=1", i, operand_o, operand_valid_o);
          end
          if (rx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready%0d: got %b, want 0", i, rx_ready_o);
          end
          @(negedge clk_i);
        end
        rdy_mode = 1;
      end
    join
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain: got timeout, want idle"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i].opc !== exp_q[i].opc || obs_q[i].word !== exp_q[i].word || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL bp_word%0d: got op=%h last=%b, want op=%h last=%b", i,
                 obs_q[i].word, obs_q[i].last, exp_q[i].word, exp_q[i].last);
      end
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] raw [8] = '{8'h11, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bq_t f1;
    bq_t f2;
    bit  ok;
    clear_sb();
    rdy_mode = 2;
    make_frame(8'h7F, 16'h000C, f1);
    foreach (raw[i]) f2.push_back(raw[i]);
    send_frame(f1, 2);
    send_frame(f2, 2);
    wait_idle(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL badop_drain: got timeout, want idle"); end
    if (err_seen != 1) begin errors++; $display("FAIL badop_err: got %0d pulses, want 1", err_seen); end
    if (obs_q.size() != 1 || obs_q[0].word !== 32'hDEADBEEF || obs_q[0].opc !== 8'h11 || obs_q[0].last !== 1'b1) begin
      errors++;
      $display("FAIL badop_word: got %0d words first=%h, want 1 word DEADBEEF opc 11 last 1",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].word : 32'h0);
    end
  endtask

  task automatic test_bad_length();
    bq_t f1;
    bq_t f2;
    bit  ok;
    clear_sb();
    rdy_mode = 1;
    make_frame(8'h12, 16'h0009, f1);
    make_frame(8'h10, 16'h0010, f2);
    send_frame(f1, 1);
    send_frame(f2, 1);
    wait_idle(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL badlen_drain: got timeout, want idle"); end
    if (err_seen != 1) begin errors++; $display("FAIL badlen_err: got %0d pulses, want 1", err_seen); end
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL badlen_count: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i].opc !== exp_q[i].opc || obs_q[i].word !== exp_q[i].word || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL badlen_word%0d: got op=%h last=%b, want op=%h last=%b", i,
                 obs_q[i].word, obs_q[i].last, exp_q[i].word, exp_q[i].last);
      end
    end
  endtask

  task automatic test_size_limits();
    bq_t f;
    bit  ok;
    clear_sb();
    rdy_mode = 1;
    make_frame(8'h10, 16'h0404, f);   // one word over the limit
    send_frame(f, 0);
    make_frame(8'h10, 16'h0004, f);   // header only
    send_frame(f, 0);
    make_frame(8'h12, 16'(MaxLen), f); // exactly at the limit
    send_frame(f, 0);
    make_frame(8'h11, 16'h000C, f);
    send_frame(f, 0);
    wait_idle(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL size_drain: got timeout, want idle"); end
    if (err_seen != 2) begin errors++; $display("FAIL size_err: got %0d pulses, want 2", err_seen); end
    if (obs_q.size() != 257) begin errors++; $display("FAIL size_count: got %0d, want 257", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i].opc !== exp_q[i].opc || obs_q[i].word !== exp_q[i].word || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL size_word%0d: got opc=%h op=%h last=%b, want opc=%h op=%h last=%b", i,
                 obs_q[i].opc, obs_q[i].word, obs_q[i].last, exp_q[i].opc, exp_q[i].word, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bq_t f;
    bit  ok;
    clear_sb();
    rdy_mode = 1;
    make_frame(8'h11, 16'h0010, f);
    for (int i = 0; i < 6; i++) send_byte(f[i], 0);
    #3;
    rst_ni = 1'b0;
    #1;
    checks += 6;
    if (operand_o !== 32'h0)      begin errors++; $display("FAIL mid_rst_operand: got %h, want 0", operand_o); end
    if (opcode_o !== 8'h0)        begin errors++; $display("FAIL mid_rst_opcode: got %h, want 0", opcode_o); end
    if (operand_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, want 0", operand_valid_o); end
    if (operand_last_o !== 1'b0)  begin errors++; $display("FAIL mid_rst_last: got %b, want 0", operand_last_o); end
    if (frame_err_o !== 1'b0)     begin errors++; $display("FAIL mid_rst_err: got %b, want 0", frame_err_o); end
    if (rx_ready_o !== 1'b1)      begin errors++; $display("FAIL mid_rst_ready: got %b, want 1", rx_ready_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    clear_sb();
    make_frame(8'h12, 16'h000C, f);
    send_frame(f, 1);
    wait_idle(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL mid_drain: got timeout, want idle"); end
    if (err_seen != 0) begin errors++; $display("FAIL mid_err: got %0d pulses, want 0", err_seen); end
    if (obs_q.size() != 2) begin errors++; $display("FAIL mid_count: got %0d, want 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i].opc !== exp_q[i].opc || obs_q[i].word !== exp_q[i].word || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL mid_word%0d: got opc=%h op=%h last=%b, want opc=%h op=%h last=%b", i,
                 obs_q[i].opc, obs_q[i].word, obs_q[i].last, exp_q[i].opc, exp_q[i].word, exp_q[i].last);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] legal_ops [3] = '{8'h10, 8'h11, 8'h12};
    bq_t         f;
    bit          ok;
    logic [7:0]  opc;
    logic [15:0] len;
    clear_sb();
    rdy_mode = 2;
    for (int n = 0; n < 30; n++) begin
      opc = ($urandom_range(3, 0) != 0) ? legal_ops[$urandom_range(2, 0)] : 8'($urandom);
      len = ($urandom_range(9, 0) < 6) ? 16'(4 * $urandom_range(16, 2)) : 16'($urandom_range(40, 0));
      make_frame(opc, len, f);
      send_frame(f, 3);
    end
    wait_idle(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL rand_drain: got timeout, want idle"); end
    if (err_seen != exp_err) begin errors++; $display("FAIL rand_err: got %0d pulses, want %0d", err_seen, exp_err); end
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i].opc !== exp_q[i].opc || obs_q[i].word !== exp_q[i].word || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL rand_word%0d: got opc=%h op=%h last=%b, want opc=%h op=%h last=%b", i,
                 obs_q[i].opc, obs_q[i].word, obs_q[i].last, exp_q[i].opc, exp_q[i].word, exp_q[i].last);
      end
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    test_reset();
    test_add_frame();
    test_backpressure();
    test_bad_opcode();
    test_bad_length();
    test_size_limits();
    test_reset_mid_frame();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_frame_parser.md
UART_ALU_FRAME_PARSER -- requirements
Module: uart_alu_frame_parser

Interface
REQ-001 SHALL have parameter MaxLenP, default 1024, the maximum legal frame length in bytes, header included.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_data_i, input, 8, received byte from the UART RX stage.
REQ-005 SHALL have port rx_valid_i, input, 1, rx_data_i holds a valid byte.
REQ-006 SHALL have port rx_ready_o, output, 1, parser accepts a byte; a transfer occurs when rx_valid_i and rx_ready_o are both high.
REQ-007 SHALL have port opcode_o, output, 8, opcode of the frame currently being emitted.
REQ-008 SHALL have port operand_o, output, 32, assembled operand word.
REQ-009 SHALL have port operand_valid_o, output, 1, operand_o, opcode_o and operand_last_o are valid.
REQ-010 SHALL have port operand_ready_i, input, 1, the downstream ALU accepts the word.
REQ-011 SHALL have port operand_last_o, output, 1, the word is the final operand of the frame.
REQ-012 SHALL have port frame_err_o, output, 1, one-cycle pulse when a frame is rejected.

Function
REQ-013 SHALL parse frames of the form: opcode byte, reserved byte, length LSB, length MSB, then (length-4)/4 operands, each 32 bits and little-endian.
REQ-014 SHALL accept only the legal opcodes 0x10 (add), 0x11 (mul) and 0x12 (div).
REQ-015 SHALL implement the states OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, EMIT and DROP.
REQ-016 SHALL move OPCODE->RSVD->LEN_LO->LEN_HI, one accepted byte per step; the reserved byte is ignored.
REQ-017 SHALL treat a frame as legal when the opcode is legal, length >= 8, length <= MaxLenP, and length[1:0] == 0.
REQ-018 SHALL, on accepting the LEN_HI byte of a legal frame, load a 16-bit remaining-byte counter with length-4 and go to PAYLOAD.
REQ-019 SHALL, on accepting the LEN_HI byte of an illegal frame, pulse frame_err_o for one cycle.
REQ-020 SHALL, for an illegal frame with length > 4, load the counter with length-4 and go to DROP.
REQ-021 SHALL, for an illegal frame with length <= 4, return to OPCODE.
REQ-022 SHALL, in PAYLOAD, shift each accepted byte into operand bits [8k+7:8k] for k = 0..3 and decrement the counter.
REQ-023 SHALL, on accepting the 4th byte of a word, assert operand_valid_o the next cycle, go to EMIT, and set operand_last_o when the counter reaches 0.
REQ-024 SHALL hold rx_ready_o low in EMIT.
REQ-025 SHALL hold operand_o, opcode_o, operand_last_o and operand_valid_o stable in EMIT until operand_ready_i is high.
REQ-026 SHALL, when EMIT completes, go to PAYLOAD if the counter is nonzero, else to OPCODE.
REQ-027 SHALL drive rx_ready_o high in every other state; rx_ready_o SHALL be a registered-state decode only, not a combinational function of rx_valid_i.
REQ-028 SHALL, in DROP, accept and discard bytes while decrementing the counter, and go to OPCODE when it reaches 0.
REQ-029 SHALL NOT assert operand_valid_o for any dropped frame.
REQ-030 SHALL register the opcode when it is accepted in OPCODE; opcode_o SHALL keep that value until the next opcode byte is accepted.
REQ-031 SHALL treat rx_valid_i low as a stall in any state, with no state change.
REQ-032 SHALL have no inter-byte timeout.
REQ-033 SHALL have a word-accept-to-valid latency of 1 cycle.
REQ-034 SHALL sustain a peak throughput of one operand per 5 cycles when operand_ready_i is held high.

Reset
REQ-035 SHALL, with rst_ni low, immediately force state OPCODE, counter 0, operand_o 0, opcode_o 0, operand_valid_o 0, operand_last_o 0, frame_err_o 0 and rx_ready_o 1.
REQ-036 SHALL, when reset asserts mid-frame, discard the partial frame and any pending operand word.
REQ-037 SHALL NOT accept any byte in the cycle rst_ni deasserts; the first byte SHALL be accepted on the following rising edge.

Verification
REQ-038 SHALL cover add frame 10 00 0C 00 | 01 00 00 00 | 02 00 00 00 with operand_ready_i=1 -> operands 0x00000001 (last=0) then 0x00000002 (last=1), opcode_o=0x10, no frame_err_o.
REQ-039 SHALL cover backpressure, the same frame with operand_ready_i low for 10 cycles after the first word -> operand_o held at 0x00000001, rx_ready_o=0 throughout, then the sequence completes unchanged.
REQ-040 SHALL cover bad opcode 0x7F with length 0x000C plus 8 payload bytes, followed by frame 11 00 08 00 EF BE AD DE -> one frame_err_o pulse, no operands from the first frame, then 0xDEADBEEF last=1 opcode 0x11.
REQ-041 SHALL cover bad length 0x0009 with opcode 0x12 -> frame_err_o pulse and 5 bytes dropped.
REQ-042 SHALL cover an oversize frame, length 0x0404 with MaxLenP=1024 -> frame_err_o pulse and 1024 payload bytes dropped, after which the next legal frame parses correctly.
REQ-043 SHALL cover reset mid-frame, rst_ni pulsed low after 6 bytes -> all outputs at reset values, and the next full frame parses from its first byte.
